// File: rtl/seg7_2_bcd_scan_if.sv
// seg7_2_bcd_scan_if: frame handshake from the display scanner to its consumer.
// With SEG7_DP_EN the frame also carries one decimal-point bit per digit.
interface seg7_2_bcd_scan_if #(
    parameter int DIGITS = 4
);
    logic                frame_valid;
    logic                frame_ready;
    logic [4*DIGITS-1:0] frame_bcd;
    logic [DIGITS-1:0]   frame_err;
    logic                overflow;
`ifdef SEG7_DP_EN
    logic [DIGITS-1:0]   frame_dp;
    modport master (output frame_valid, frame_bcd, frame_err, frame_dp, overflow, input frame_ready);
    modport slave  (input frame_valid, frame_bcd, frame_err, frame_dp, overflow, output frame_ready);
`else
    modport master (output frame_valid, frame_bcd, frame_err, overflow, input frame_ready);
    modport slave  (input frame_valid, frame_bcd, frame_err, overflow, output frame_ready);
`endif
endinterface

// File: rtl/seg7_2_bcd_scan.sv
// seg7_2_bcd_scan: samples a multiplexed 7-segment display, decodes each stable digit and emits whole frames.
// Defining SEG7_DP_EN adds the seg_dp_n input and the per-digit frame_dp output.
module seg7_2_bcd_scan #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_n,
    input  logic [DIGITS-1:0] an_n,
`ifdef SEG7_DP_EN
    input  logic              seg_dp_n,
`endif
    seg7_2_bcd_scan_if.master frm
);
    typedef enum logic {SCAN, LATCHED} state_t;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    state_t              state, state_n;
    logic [6:0]          seg_q, seg_p;
    logic [DIGITS-1:0]   an_q, an_p;
    logic [7:0]          cnt, cnt_n;
    logic                sel, same, cap, done, load, drop, hs;
    logic [IW-1:0]       k;
    logic [3:0]          dig;
    logic                dig_err;
    logic [4*DIGITS-1:0] slot_bcd;
    logic [DIGITS-1:0]   slot_err, captured;

    // Current sample (q) and the one before it (p) for the stability comparison
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            seg_q <= '0;
            seg_p <= '0;
            an_q  <= '0;
            an_p  <= '0;
        end else begin
            seg_q <= seg_n;
            seg_p <= seg_q;
            an_q  <= an_n;
            an_p  <= an_q;
        end

`ifdef SEG7_DP_EN
    logic              dp_q, dp_p;
    logic [DIGITS-1:0] slot_dp;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dp_q         <= 1'b0;
            dp_p         <= 1'b0;
            slot_dp      <= '0;
            frm.frame_dp <= '0;
        end else begin
            dp_q <= seg_dp_n;
            dp_p <= dp_q;
            if (cap) slot_dp[k] <= ~dp_q;
            if (load) frm.frame_dp <= slot_dp;
        end
    assign same = seg_q == seg_p && an_q == an_p && dp_q == dp_p;
`else
    assign same = seg_q == seg_p && an_q == an_p;
`endif

    assign sel = $onehot(~an_q);

    always_comb begin
        k = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!an_q[i]) k = IW'(i);
    end

    always_comb begin
        dig     = 4'hF;
        dig_err = 1'b1;
        case (seg_q)
            7'b1000000: {dig, dig_err} = {4'h0, 1'b0};
            7'b1111001: {dig, dig_err} = {4'h1, 1'b0};
            7'b0100100: {dig, dig_err} = {4'h2, 1'b0};
            7'b0110000: {dig, dig_err} = {4'h3, 1'b0};
            7'b0011001: {dig, dig_err} = {4'h4, 1'b0};
            7'b0010010: {dig, dig_err} = {4'h5, 1'b0};
            7'b0000010: {dig, dig_err} = {4'h6, 1'b0};
            7'b1111000: {dig, dig_err} = {4'h7, 1'b0};
            7'b0000000: {dig, dig_err} = {4'h8, 1'b0};
            7'b0010000: {dig, dig_err} = {4'h9, 1'b0};
            7'b0000110: {dig, dig_err} = {4'hE, 1'b0};
            default:    {dig, dig_err} = {4'hF, 1'b1};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= SCAN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end

    always_comb state_n = cap ? LATCHED : (state == LATCHED && same) ? LATCHED : SCAN;

    // Leaving LATCHED reloads the counter, so STABLE_CYCLES=1 captures the new digit at once
    always_comb begin
        cnt_n = !sel ? 8'd0 : same ? (cnt == 8'hFF ? cnt : cnt + 8'd1) : 8'd1;
        cap   = cnt_n == 8'(STABLE_CYCLES) && (state == SCAN || !same);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            slot_bcd <= '0;
            slot_err <= '0;
            captured <= '0;
        end else begin
            if (cap) begin
                slot_bcd[{k, 2'b00} +: 4] <= dig;
                slot_err[k]               <= dig_err;
            end
            captured <= (done ? '0 : captured) | (cap ? DIGITS'(1) << k : '0);
        end

    assign done = &captured;
    assign hs   = frm.frame_valid && frm.frame_ready;
    assign load = done && (!frm.frame_valid || frm.frame_ready);
    assign drop = done && !load;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            frm.frame_valid <= 1'b0;
            frm.frame_bcd   <= '0;
            frm.frame_err   <= '0;
            frm.overflow    <= 1'b0;
        end else begin
            frm.frame_valid <= load || (frm.frame_valid && !frm.frame_ready);
            if (load) begin
                frm.frame_bcd <= slot_bcd;
                frm.frame_err <= slot_err;
            end
            frm.overflow <= drop || (frm.overflow && !hs);
        end
endmodule

// File: doc/seg7_2_bcd_scan.md
SEG7_2_BCD_SCAN -- requirements
Module: seg7_2_bcd_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of multiplexed digit positions (legal 1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 3, giving the consecutive identical samples needed to accept a digit (legal 1..255).
REQ-003 SHALL have port clk  input  1  the single clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port seg_n  input  7  active-low segments; bit6=g … bit0=a.
REQ-006 SHALL have port an_n  input  DIGITS  active-low digit enables; bit0 is the least-significant digit.
REQ-007 SHALL have port frame_ready  input  1  consumer accepts the frame.
REQ-008 SHALL have port frame_valid  output  1  a complete frame is held on the outputs.
REQ-009 SHALL have port frame_bcd  output  4*DIGITS  decoded digits; nibble k belongs to digit k.
REQ-010 SHALL have port frame_err  output  DIGITS  bit k set when the pattern for digit k was undecodable.
REQ-011 SHALL have port overflow  output  1  sticky flag: a completed frame was dropped.

Function
REQ-012 SHALL register seg_n and an_n once on entry; all later logic uses the registered copies only.
REQ-013 SHALL treat a sample as a select only when exactly one bit of an_n is 0; zero or multiple low bits SHALL be a non-select.
REQ-014 SHALL run a 2-state FSM: SCAN counts identical consecutive select samples; LATCHED waits for change.
REQ-015 In SCAN, a sample equal to the previous sample SHALL increment the stability counter (saturating); any difference or non-select SHALL reload it to 1 (0 for non-select).
REQ-016 When the counter reaches STABLE_CYCLES, the FSM SHALL capture the decoded digit into slot k, set captured[k], and enter LATCHED in the same cycle.
REQ-017 In LATCHED, the FSM SHALL return to SCAN on the first sample differing in seg_n or an_n, with the counter reloaded per REQ-015.
REQ-018 Decode SHALL map 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0000110→4'hE, all with err=0.
REQ-019 Any other pattern SHALL decode to 4'hF with err=1.
REQ-020 A capture into an already-captured slot before frame completion SHALL overwrite that slot.
REQ-021 When every captured bit is 1, the frame SHALL be complete; captured SHALL clear on the next edge.
REQ-022 A completed frame SHALL load frame_bcd/frame_err and assert frame_valid one cycle after the completing capture, provided frame_valid is 0 or frame_ready is 1 in that cycle.
REQ-023 Otherwise the completed frame SHALL be discarded, the held frame SHALL remain unchanged, and overflow SHALL be set.
REQ-024 frame_valid SHALL stay high with stable data until a cycle where frame_valid and frame_ready are both 1; it SHALL then drop unless a new frame loads in that same cycle.
REQ-025 overflow SHALL clear only on a completed handshake or on reset; a simultaneous handshake and drop SHALL leave overflow set.
REQ-026 Minimum latency SHALL be 1 (input register) + STABLE_CYCLES + 1 cycles from the last digit appearing to frame_valid.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear frame_valid, frame_bcd, frame_err, overflow, captured, the counter, and the input registers to 0, and set the FSM to SCAN.
REQ-028 Reset mid-frame SHALL discard all partial captures; after release, the first frame SHALL require fresh captures of all DIGITS slots.
REQ-029 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high; no output SHALL glitch high during reset.

Configuration
REQ-030 When macro SEG7_DP_EN is defined, the block SHALL add input seg_dp_n (1 bit, active-low decimal point) and output frame_dp (DIGITS bits).
REQ-031 With SEG7_DP_EN, seg_dp_n SHALL take part in the stability comparison and SHALL be captured per slot as frame_dp[k] = ~seg_dp_n.
REQ-032 Without SEG7_DP_EN, neither port SHALL exist, and behaviour SHALL be otherwise identical.

Verification
REQ-033 Bench SHALL drive DIGITS=4, STABLE_CYCLES=3, digits 1,2,3,4 each held 5 cycles with frame_ready=1 -> frame_bcd=16'h4321, frame_err=0, and frame_valid pulsing once.
REQ-034 Bench SHALL drive digit 2 as 1111111 -> nibble2=4'hF and frame_err=4'b0100.
REQ-035 Bench SHALL hold each digit for only 2 cycles -> no capture and frame_valid stays 0.
REQ-036 Bench SHALL keep frame_ready=0 and complete two frames -> the first frame is held and overflow=1; one handshake then clears both frame_valid and overflow.
REQ-037 Bench SHALL drive an_n=4'b1100 for 10 cycles -> no capture, and the counter is 0.
REQ-038 Bench SHALL pulse rst_n low after 3 of 4 captures -> all outputs are 0, and the next frame requires 4 new captures.
